usb_tx_sequencer: RTL and testbench
===================================

// Module: usb_tx_sequencer
// PURPOSE
//  Packet-level controller for the byte-serial USB transmitter (usb_tx).
//  Arbitrates between a handshake requester (ACK/NAK/STALL) and a data-packet requester (DATA0/DATA1).
//  Builds PID | payload | CRC16 byte streams and drives the transmitter's data/valid/ready handshake.
//  Enforces an inter-packet gap so back-to-back packets never merge.
// PARAMETERS
//  MAX_LEN     64  maximum payload bytes per data packet; buffer address width is $clog2(MAX_LEN)
//  IPG_CYCLES  32  clk cycles idle after tx_valid falls before the next packet may start (covers EOP + gap)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  hs_req     in   1   handshake request; level, held until hs_done
//  hs_pid     in   4   handshake PID (pid_t: ACK=4'b0010, NAK=4'b1010, STALL=4'b1110)
//  hs_done    out  1   one-cycle pulse: handshake packet fully handed to transmitter and gap elapsed
//  dat_req    in   1   data request; level, held until dat_done
//  dat_pid    in   4   DATA0=4'b0011 / DATA1=4'b1011
//  dat_len    in   $clog2(MAX_LEN+1)  payload length 0..MAX_LEN; sampled at grant
//  dat_done   out  1   one-cycle pulse: data packet complete and gap elapsed
//  rd_addr    out  $clog2(MAX_LEN)    payload buffer read address
//  rd_data    in   8   buffer read data, valid the cycle after rd_addr (1-cycle latency)
//  tx_data    out  8   byte to transmitter (sampled by usb_tx when tx_ready=1)
//  tx_valid   out  1   rise=start SYNC, high=bytes pending, fall=EOP
//  tx_ready   in   1   transmitter pulse: tx_data accepted / previous byte sent
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; tx_valid=0, tx_data=0, rd_addr=0, hs_done=0, dat_done=0, busy=0; CRC reg=16'hFFFF.
//  All outputs registered.
//  Arbitration (IDLE only): hs_req wins over dat_req when both are high.
//   Grant latches pid, kind and len; later changes on request inputs are ignored until done.
//  PID byte = {~pid, pid}; e.g. ACK -> 8'hD2, DATA0 -> 8'hC3, DATA1 -> 8'h4B.
//  FSM:
//   IDLE  -> on grant: tx_valid<=1, tx_data<=PID byte, rd_addr<=0, crc<=FFFF, byte count<=0; go SYNC.
//   SYNC  -> wait tx_ready (PID accepted):
//            handshake -> LAST; data with len=0 -> CRC_LO; else -> DATA.
//            For data, rd_addr=0 is issued in IDLE so rd_data is ready by the first tx_ready.
//   DATA  -> tx_data=rd_data of current byte, presented before the tx_ready that consumes it.
//            On each tx_ready: fold byte into CRC, count++, rd_addr++.
//            After byte len-1 is accepted -> CRC_LO.
//   CRC_LO-> tx_data=~crc[7:0]; on tx_ready -> CRC_HI.
//   CRC_HI-> tx_data=~crc[15:8]; on tx_ready -> LAST.
//   LAST  -> hold tx_valid=1 until the next tx_ready (final byte shifted out).
//            Cycle after it: tx_valid<=0 -> GAP.
//   GAP   -> count IPG_CYCLES; then pulse hs_done or dat_done for 1 cycle -> IDLE.
//  tx_data changes only in the cycle after a tx_ready (or at grant); stable during tx_ready.
//  CRC: CRC-16/USB, poly 16'h8005 reflected (16'hA001 LSB-first), init FFFF.
//   Computed over payload only; transmitted complemented, low byte first.
//  rd_addr wraps never: max issued address = len-1; no read beyond len.
//  Simultaneous: a new request asserted during GAP is served only after IDLE is re-entered (1 idle cycle min).
//  tx_ready while IDLE/GAP: ignored.
//  dat_len > MAX_LEN: clamped to MAX_LEN.
//  Reset mid-packet: immediate IDLE, tx_valid=0 next cycle, no done pulse.
// STRUCTURE
//  types package: pid_t enum (ACK, NAK, STALL, DATA0, DATA1), CRC16_POLY=16'hA001, CRC16_INIT=16'hFFFF,
//   CRC16_RESIDUAL=16'hB001.
//  Sub-module usb_crc16: byte-wise combinational next-CRC function (crc_in, byte) -> crc_out,
//   reused later by the receiver.
//  usb_tx_sequencer: arbiter + FSM + byte counter + gap counter + output regs.
// TESTING (bench models usb_tx: tx_ready pulse every 32 clk after tx_valid rise)
//  1 hs_req=1, hs_pid=ACK -> tx_data D2 on 1st tx_ready; tx_valid falls after 2nd tx_ready;
//    hs_done 1 pulse after IPG_CYCLES.
//  2 dat_req, DATA0, len=0 -> bytes C3 00 00; dat_done once.
//  3 dat_req, DATA1, len=9, buffer "123456789" (31..39) -> 4B 31 32 ... 39 C8 B4
//    (CRC-16/USB check B4C8 low byte first); rd_addr 0..8 only.
//  4 hs_req and dat_req rise same cycle -> handshake sent first, data packet starts >= IPG_CYCLES+1 later.
//  5 len=64 of incrementing bytes -> 67 bytes out matching reference CRC model;
//    dat_len changed mid-packet has no effect.
//  6 reset asserted mid-DATA -> tx_valid=0 next cycle, busy=0, no done pulse; a new ACK then sends cleanly.

Source files
------------

// File: rtl/usb_tx_sequencer_pkg.sv
// Shared types and constants for the USB transmit path.
//   pid_t        : 4-bit packet identifiers used by the sequencer.
//   seq_state_t  : packet sequencer states.
//   CRC16_*      : CRC-16/USB constants (reflected polynomial, LSB-first).
//   pid_byte()   : builds the on-wire PID byte {~pid, pid}.
package usb_tx_sequencer_pkg;

  typedef enum logic [3:0] {
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011
  } pid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_LAST,
    ST_GAP
  } seq_state_t;

  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  // Register value left after a good payload+CRC has been folded in.
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_tx_sequencer_crc16.sv
// usb_crc16: byte-wise combinational CRC-16/USB update.
//   crc_in  [15:0] : current CRC register
//   data_in [7:0]  : byte to fold in, processed LSB first
//   crc_out [15:0] : updated CRC register
module usb_crc16
  import usb_tx_sequencer_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data_in};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: packet-level controller for the byte-serial USB transmitter.
// Arbitrates handshake vs data requests (handshake wins), streams
// PID | payload | CRC16 to usb_tx, then holds an inter-packet gap.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   hs_req/hs_pid     : handshake request (level) and its PID
//   hs_done           : one-cycle pulse when the handshake packet and gap are complete
//   dat_req/dat_pid   : data request (level) and DATA0/DATA1 PID
//   dat_len           : payload length, sampled at grant, clamped to MAX_LEN
//   dat_done          : one-cycle pulse when the data packet and gap are complete
//   rd_addr/rd_data   : payload buffer port, 1-cycle read latency
//   tx_data/tx_valid  : byte stream to usb_tx
//   tx_ready          : usb_tx accept pulse
//   busy              : high whenever not idle
module usb_tx_sequencer
  import usb_tx_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 64,
  parameter int unsigned IPG_CYCLES = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hs_req,
  input  logic [3:0]                   hs_pid,
  output logic                         hs_done,
  input  logic                         dat_req,
  input  logic [3:0]                   dat_pid,
  input  logic [$clog2(MAX_LEN+1)-1:0] dat_len,
  output logic                         dat_done,
  output logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  input  logic [7:0]                   rd_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy
);

  localparam int unsigned ADDR_W = $clog2(MAX_LEN);
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned GAP_W  = $clog2(IPG_CYCLES + 1);

  seq_state_t        state_q,    state_d;
  pid_t              pid_q,      pid_d;
  logic              is_data_q,  is_data_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [LEN_W-1:0]  cnt_q,      cnt_d;
  logic [GAP_W-1:0]  gap_q,      gap_d;
  logic [15:0]       crc_q,      crc_d;
  logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [7:0]        tx_data_q,  tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              hs_done_q,  hs_done_d;
  logic              dat_done_q, dat_done_d;
  logic              busy_q,     busy_d;

  logic [15:0]       crc_next;
  logic [LEN_W-1:0]  addr_ext;
  logic              addr_more;

  // CRC is folded over the byte being accepted, i.e. the one currently on tx_data.
  usb_crc16 u_crc (
    .crc_in  (crc_q),
    .data_in (tx_data_q),
    .crc_out (crc_next)
  );

  // rd_addr runs one byte ahead of tx_data so the next byte is already on
  // rd_data when tx_ready arrives; it stops at len-1.
  assign addr_ext  = LEN_W'(rd_addr_q);
  assign addr_more = (addr_ext + LEN_W'(1)) < len_q;

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    is_data_d  = is_data_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    crc_d      = crc_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    hs_done_d  = 1'b0;
    dat_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The done-pulse cycle is an enforced idle cycle so a requester that
        // drops its level one cycle late is not served twice.
        if (!hs_done_q && !dat_done_q && (hs_req || dat_req)) begin
          state_d    = ST_SYNC;
          tx_valid_d = 1'b1;
          rd_addr_d  = '0;
          crc_d      = CRC16_INIT;
          cnt_d      = '0;
          if (hs_req) begin
            is_data_d = 1'b0;
            pid_d     = pid_t'(hs_pid);
            len_d     = '0;
          end else begin
            is_data_d = 1'b1;
            pid_d     = pid_t'(dat_pid);
            len_d     = (dat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : dat_len;
          end
          tx_data_d = pid_byte(pid_d);
        end
      end

      ST_SYNC: begin
        if (tx_ready) begin
          if (!is_data_q) begin
            state_d = ST_LAST;
          end else if (len_q == '0) begin
            state_d   = ST_CRC_LO;
            tx_data_d = ~crc_q[7:0];
          end else begin
            state_d   = ST_DATA;
            tx_data_d = rd_data;
            if (addr_more) rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tx_ready) begin
          crc_d = crc_next;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d   = ST_CRC_LO;
            tx_data_d = ~crc_next[7:0];
          end else begin
            tx_data_d = rd_data;
            if (addr_more) rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end

      ST_CRC_LO: begin
        if (tx_ready) begin
          state_d   = ST_CRC_HI;
          tx_data_d = ~crc_q[15:8];
        end
      end

      ST_CRC_HI: begin
        if (tx_ready) state_d = ST_LAST;
      end

      ST_LAST: begin
        // This tx_ready marks the final byte shifted out; dropping tx_valid signals EOP.
        if (tx_ready) begin
          state_d    = ST_GAP;
          tx_valid_d = 1'b0;
          gap_d      = '0;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_W'(IPG_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          hs_done_d  = !is_data_q;
          dat_done_d = is_data_q;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pid_q      <= PID_ACK;
      is_data_q  <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      crc_q      <= CRC16_INIT;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      hs_done_q  <= 1'b0;
      dat_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      is_data_q  <= is_data_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      crc_q      <= crc_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      hs_done_q  <= hs_done_d;
      dat_done_q <= dat_done_d;
      busy_q     <= busy_d;
    end
  end

  assign hs_done  = hs_done_q;
  assign dat_done = dat_done_q;
  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Testbench for usb_tx_sequencer: models usb_tx (tx_ready every 32 clk while
// tx_valid is high) and a 1-cycle-latency payload buffer; expected packets and
// done pulses are queued by the stimulus and checked by a negedge monitor.
module tb_usb_tx_sequencer;
  import usb_tx_sequencer_pkg::*;

  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned IPG     = 32;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned ADDR_W  = $clog2(MAX_LEN);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hs_req = 1'b0;
  logic [3:0]        hs_pid = 4'h0;
  logic              hs_done;
  logic              dat_req = 1'b0;
  logic [3:0]        dat_pid = 4'h0;
  logic [LEN_W-1:0]  dat_len = '0;
  logic              dat_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'h00;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              busy;

  always #5 clk = ~clk;

  usb_tx_sequencer #(.MAX_LEN(MAX_LEN), .IPG_CYCLES(IPG)) dut (
    .clk(clk), .reset(reset),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_done(hs_done),
    .dat_req(dat_req), .dat_pid(dat_pid), .dat_len(dat_len), .dat_done(dat_done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  logic [7:0] mem [MAX_LEN];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_byte_q [$];
  int         exp_len_q  [$];
  int         exp_max_q  [$];
  bit         exp_done_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // usb_tx model
  initial begin
    int unsigned rc;
    rc = 0;
    forever begin
      @(posedge clk); #1;
      tx_ready = 1'b0;
      if (tx_valid) begin
        rc++;
        if (rc == 32) begin
          tx_ready = 1'b1;
          rc = 0;
        end
      end else begin
        rc = 0;
      end
    end
  end

  // Monitor / scoreboard
  logic [7:0] cap [$];
  logic       prev_valid = 1'b0;
  int         fall_cyc = -1;
  int         max_addr = 0;

  task automatic check_packet();
    int n, ma, got;
    logic [7:0] e;
    got = int'(cap.size()) - 1;  // last capture is the EOP-trigger ready, not a new byte
    if (exp_len_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_packet: got %0d bytes, expected no packet", got);
    end else begin
      n  = exp_len_q.pop_front();
      ma = exp_max_q.pop_front();
      chk("packet_len", got, n);
      chk("max_rd_addr", max_addr, ma);
      for (int i = 0; i < n; i++) begin
        e = exp_byte_q.pop_front();
        if (i < got) chk($sformatf("byte%0d", i), int'(cap[i]), int'(e));
      end
    end
    cap.delete();
  endtask

  task automatic check_done();
    bit k;
    if (exp_done_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: hs_done=%0d dat_done=%0d, expected none", hs_done, dat_done);
    end else begin
      k = exp_done_q.pop_front();
      chk("done_kind_dat", int'(dat_done), int'(k));
      chk("done_kind_hs", int'(hs_done), int'(!k));
      chk("done_delay", cyc - fall_cyc, IPG);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cap.delete();
        fall_cyc   = -1;
        prev_valid = 1'b0;
      end else begin
        if (tx_valid && !prev_valid) begin
          if (fall_cyc >= 0) begin
            checks++;
            if (cyc - fall_cyc < int'(IPG) + 1) begin
              errors++;
              $display("FAIL ipg_min: gap %0d cycles, required >= %0d", cyc - fall_cyc, IPG + 1);
            end
          end
          cap.delete();
          max_addr = 0;
        end
        if (tx_valid && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        if (tx_valid && tx_ready) cap.push_back(tx_data);
        if (!tx_valid && prev_valid) begin
          fall_cyc = cyc;
          check_packet();
        end
        if (hs_done || dat_done) check_done();
        prev_valid = tx_valid;
      end
    end
  end

  // Reference CRC-16/USB, bit-serial over mem[0..n-1]
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ mem[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic push_meta(input int n, input int ma, input bit is_dat);
    exp_len_q.push_back(n);
    exp_max_q.push_back(ma);
    exp_done_q.push_back(is_dat);
  endtask

  task automatic push_hs(input logic [7:0] b);
    exp_byte_q.push_back(b);
    push_meta(1, 0, 1'b0);
  endtask

  task automatic push_dat_model(input logic [7:0] pid_b, input int n);
    logic [15:0] c;
    c = ref_crc(n);
    exp_byte_q.push_back(pid_b);
    for (int k = 0; k < n; k++) exp_byte_q.push_back(mem[k]);
    exp_byte_q.push_back(~c[7:0]);
    exp_byte_q.push_back(~c[15:8]);
    push_meta(n + 3, (n == 0) ? 0 : n - 1, 1'b1);
  endtask

  // Waits for the done pulse, then one more cycle (registered requester).
  task automatic wait_done(input bit want_dat, input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk); #1;
      if (want_dat ? dat_done : hs_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no pulse within 8000 cycles", nm);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_hs(input logic [3:0] pid);
    hs_pid = pid;
    hs_req = 1'b1;
    wait_done(1'b0, "hs_done");
    hs_req = 1'b0;
  endtask

  task automatic send_dat(input logic [3:0] pid, input int len);
    dat_pid = pid;
    dat_len = LEN_W'(len);
    dat_req = 1'b1;
    wait_done(1'b1, "dat_done");
    dat_req = 1'b0;
  endtask

  initial begin
    logic [7:0] v3 [12];
    bit got;
    v3 = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    for (int i = 0; i < int'(MAX_LEN); i++) mem[i] = 8'h00;

    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hs_done", int'(hs_done), 0);
    chk("rst_dat_done", int'(dat_done), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 1: handshakes
    push_hs(8'hD2); send_hs(PID_ACK);
    push_hs(8'h5A); send_hs(PID_NAK);
    push_hs(8'h1E); send_hs(PID_STALL);

    // 2: zero-length DATA0
    exp_byte_q.push_back(8'hC3); exp_byte_q.push_back(8'h00); exp_byte_q.push_back(8'h00);
    push_meta(3, 0, 1'b1);
    send_dat(PID_DATA0, 0);

    // 3: "123456789" on DATA1
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 12; i++) exp_byte_q.push_back(v3[i]);
    push_meta(12, 8, 1'b1);
    dat_pid = PID_DATA1;
    dat_len = LEN_W'(9);
    dat_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_active", int'(busy), 1);
    wait_done(1'b1, "dat_done");
    dat_req = 1'b0;

    // 4: simultaneous requests, handshake first
    push_hs(8'hD2);
    exp_byte_q.push_back(8'h4B); exp_byte_q.push_back(8'h00); exp_byte_q.push_back(8'h00);
    push_meta(3, 0, 1'b1);
    hs_pid  = PID_ACK;
    dat_pid = PID_DATA1;
    dat_len = '0;
    hs_req  = 1'b1;
    dat_req = 1'b1;
    wait_done(1'b0, "hs_done");
    hs_req = 1'b0;
    wait_done(1'b1, "dat_done");
    dat_req = 1'b0;

    // 5: full-length packet, dat_len changed mid-packet
    for (int i = 0; i < int'(MAX_LEN); i++) mem[i] = 8'(i);
    push_dat_model(8'hC3, 64);
    dat_pid = PID_DATA0;
    dat_len = LEN_W'(64);
    dat_req = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    dat_len = LEN_W'(5);
    wait_done(1'b1, "dat_done");
    dat_req = 1'b0;

    // Over-length request is clamped to MAX_LEN
    for (int i = 0; i < int'(MAX_LEN); i++) mem[i] = 8'hA0 ^ 8'(i * 3);
    push_dat_model(8'h4B, 64);
    send_dat(PID_DATA1, 100);

    // Single-byte payload
    mem[0] = 8'h5C;
    push_dat_model(8'h4B, 1);
    send_dat(PID_DATA1, 1);

    // 6: reset mid-DATA, no done pulse, then a clean ACK
    dat_pid = PID_DATA0;
    dat_len = LEN_W'(9);
    dat_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (rd_addr == ADDR_W'(4)) begin
        got = 1'b1;
        break;
      end
    end
    chk("reach_mid_data", int'(got), 1);
    reset   = 1'b1;
    dat_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_tx_valid", int'(tx_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rd_addr", int'(rd_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    push_hs(8'hD2);
    send_hs(PID_ACK);

    repeat (10) @(posedge clk);
    #1;
    chk("sb_pending_pkts", exp_len_q.size(), 0);
    chk("sb_pending_done", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
